// File: rtl/cache_perf_monitor_if.sv
// Cache performance monitor bus: control pulses, instruction snoop,
// per-channel cache qualifiers and the readable counter results.
interface cache_perf_monitor_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32
);
  logic                    start_i;
  logic                    stop_i;
  logic                    clear_i;
  logic                    inst_valid_i;
  logic [31:0]             inst_i;
  logic [NUM_CH-1:0]       ch_req_i;
  logic [NUM_CH-1:0]       ch_accept_i;
  logic [NUM_CH-1:0]       ch_lookup_i;
  logic [NUM_CH-1:0]       ch_hit_i;
  logic [NUM_CH*CNT_W-1:0] access_cnt_o;
  logic [NUM_CH*CNT_W-1:0] hit_cnt_o;
  logic [NUM_CH-1:0]       overflow_o;
  logic [CNT_W-1:0]        cycle_cnt_o;
  logic [1:0]              state_o;
  logic                    done_o;
  logic                    done_pulse_o;

  // Side that drives commands and cache activity (bench / SoC glue)
  modport master (
    output start_i, stop_i, clear_i, inst_valid_i, inst_i,
           ch_req_i, ch_accept_i, ch_lookup_i, ch_hit_i,
    input  access_cnt_o, hit_cnt_o, overflow_o, cycle_cnt_o,
           state_o, done_o, done_pulse_o
  );

  // The monitor itself
  modport slave (
    input  start_i, stop_i, clear_i, inst_valid_i, inst_i,
           ch_req_i, ch_accept_i, ch_lookup_i, ch_hit_i,
    output access_cnt_o, hit_cnt_o, overflow_o, cycle_cnt_o,
           state_o, done_o, done_pulse_o
  );
endinterface

// File: rtl/cache_perf_monitor.sv
// Multi-channel cache performance monitor: counts qualified lookups and
// hits per channel while RUN, stops on a matching instruction or a software
// stop, drains for a fixed number of cycles and holds the results in DONE.

// Per-channel access/hit counter pair with sticky overflow.
module cpm_lane #(
  parameter int CNT_W  = 32,
  parameter int SAT_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             ev,
  input  logic             hit,
  output logic [CNT_W-1:0] acc_cnt,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             ovf
);
  logic acc_full, hit_full;
  assign acc_full = &acc_cnt;
  assign hit_full = &hit_cnt;

  // Hit only advances together with its access; at all-ones either hold or roll over
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt <= '0;
      hit_cnt <= '0;
      ovf     <= 1'b0;
    end else if (clr) begin
      acc_cnt <= '0;
      hit_cnt <= '0;
      ovf     <= 1'b0;
    end else if (en && ev) begin
      if (!(SAT_EN != 0 && acc_full)) acc_cnt <= acc_cnt + CNT_W'(1);
      if (hit && !(SAT_EN != 0 && hit_full)) hit_cnt <= hit_cnt + CNT_W'(1);
      if (acc_full || (hit && hit_full)) ovf <= 1'b1;
    end
  end
endmodule

module cache_perf_monitor #(
  parameter int          NUM_CH    = 2,
  parameter int          CNT_W     = 32,
  parameter logic [31:0] STOP_INST = 32'h0000_8067,
  parameter int          DRAIN_CYC = 5,
  parameter int          SAT_EN    = 1
) (
  input logic                 clk_i,
  input logic                 rst_i,
  cache_perf_monitor_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t                         state_q, state_d;
  logic [7:0]                     drain_q;
  logic [CNT_W-1:0]               cyc_q;
  logic                           pulse_q;
  logic                           run, clr_all, stop_hit;
  logic [NUM_CH-1:0]              ev;
  logic [NUM_CH-1:0][CNT_W-1:0]   acc_w, hit_w;

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state; clear wins over everything, start only matters when not busy
  always_comb begin
    state_d = state_q;
    if (bus.clear_i) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    if (bus.start_i) state_d = RUN;
        RUN:     if (stop_hit) state_d = DRAIN;
        DRAIN:   if (drain_q == 8'd0) state_d = DONE;
        DONE:    if (bus.start_i) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Decoded controls and status outputs
  always_comb begin
    run      = (state_q == RUN);
    stop_hit = bus.stop_i | (bus.inst_valid_i & (bus.inst_i == STOP_INST));
    clr_all  = bus.clear_i | (bus.start_i & ((state_q == IDLE) | (state_q == DONE)));
    bus.done_o  = (state_q == DONE);
    bus.state_o = state_q;
  end

  // Drain countdown: loaded on the stop edge, walks down to 0 inside DRAIN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                                  drain_q <= 8'd0;
    else if (bus.clear_i)                        drain_q <= 8'd0;
    else if (run && stop_hit)                    drain_q <= 8'(DRAIN_CYC - 1);
    else if (state_q == DRAIN && drain_q != 8'd0) drain_q <= drain_q - 8'd1;
  end

  // RUN cycle counter (stop cycle included) and the DONE entry pulse
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cyc_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= (state_q == DRAIN) && (state_d == DONE);
      if (clr_all) cyc_q <= '0;
      else if (run && !(SAT_EN != 0 && &cyc_q)) cyc_q <= cyc_q + CNT_W'(1);
    end
  end

  assign ev = bus.ch_req_i & bus.ch_accept_i & bus.ch_lookup_i;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    cpm_lane #(.CNT_W(CNT_W), .SAT_EN(SAT_EN)) u_lane (
      .clk     (clk_i),
      .rst_n   (rst_i),
      .clr     (clr_all),
      .en      (run),
      .ev      (ev[k]),
      .hit     (bus.ch_hit_i[k]),
      .acc_cnt (acc_w[k]),
      .hit_cnt (hit_w[k]),
      .ovf     (bus.overflow_o[k])
    );
  end

  assign bus.access_cnt_o = acc_w;
  assign bus.hit_cnt_o    = hit_w;
  assign bus.cycle_cnt_o  = cyc_q;
  assign bus.done_pulse_o = pulse_q;
endmodule

// File: tb/tb_cache_perf_monitor.sv
// Bench for cache_perf_monitor: three instances (32-bit saturating, 8-bit
// saturating, 8-bit wrapping) share one stimulus stream and one unbounded
// event-count model; each instance's view is derived by clamping or modding.
module tb_cache_perf_monitor;
  localparam int          NUM_CH = 2;
  localparam logic [31:0] STOP   = 32'h0000_8067;
  localparam int          DRAIN  = 5;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start = 0, stop = 0, clear = 0, iv = 0;
  logic [31:0] inst = '0;
  logic [NUM_CH-1:0] req = '0, acc = '0, lk = '0, hit = '0;

  cache_perf_monitor_if #(.NUM_CH(NUM_CH), .CNT_W(32)) if_a ();
  cache_perf_monitor_if #(.NUM_CH(NUM_CH), .CNT_W(8))  if_b ();
  cache_perf_monitor_if #(.NUM_CH(NUM_CH), .CNT_W(8))  if_c ();

  assign {if_a.start_i, if_a.stop_i, if_a.clear_i, if_a.inst_valid_i} = {start, stop, clear, iv};
  assign {if_b.start_i, if_b.stop_i, if_b.clear_i, if_b.inst_valid_i} = {start, stop, clear, iv};
  assign {if_c.start_i, if_c.stop_i, if_c.clear_i, if_c.inst_valid_i} = {start, stop, clear, iv};
  assign if_a.inst_i = inst;
  assign if_b.inst_i = inst;
  assign if_c.inst_i = inst;
  assign {if_a.ch_req_i, if_a.ch_accept_i, if_a.ch_lookup_i, if_a.ch_hit_i} = {req, acc, lk, hit};
  assign {if_b.ch_req_i, if_b.ch_accept_i, if_b.ch_lookup_i, if_b.ch_hit_i} = {req, acc, lk, hit};
  assign {if_c.ch_req_i, if_c.ch_accept_i, if_c.ch_lookup_i, if_c.ch_hit_i} = {req, acc, lk, hit};

  cache_perf_monitor #(.NUM_CH(NUM_CH), .CNT_W(32), .SAT_EN(1)) u_a (.clk_i(clk), .rst_i(rst_n), .bus(if_a));
  cache_perf_monitor #(.NUM_CH(NUM_CH), .CNT_W(8),  .SAT_EN(1)) u_b (.clk_i(clk), .rst_i(rst_n), .bus(if_b));
  cache_perf_monitor #(.NUM_CH(NUM_CH), .CNT_W(8),  .SAT_EN(0)) u_c (.clk_i(clk), .rst_i(rst_n), .bus(if_c));

  int checks = 0, errors = 0;

  // Reference: phase 0 IDLE, 1 RUN, 2 DRAIN, 3 DONE; raw event totals never clip
  int     ph = 0, drain_left = 0;
  longint m_acc [NUM_CH], m_hit [NUM_CH], m_cyc;
  bit     m_pulse;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] view(longint raw, int w, bit sat);
    longint mx = (longint'(1) << w) - 1;
    if (sat) return (raw > mx) ? 64'(mx) : 64'(raw);
    return 64'(raw & mx);
  endfunction

  task automatic model_zero();
    for (int k = 0; k < NUM_CH; k++) begin m_acc[k] = 0; m_hit[k] = 0; end
    m_cyc = 0;
  endtask

  task automatic model_edge();
    m_pulse = 0;
    if (clear) begin ph = 0; model_zero(); end
    else case (ph)
      0: if (start) begin ph = 1; model_zero(); end
      1: begin
        m_cyc++;
        for (int k = 0; k < NUM_CH; k++)
          if (req[k] && acc[k] && lk[k]) begin
            m_acc[k]++;
            if (hit[k]) m_hit[k]++;
          end
        if (stop || (iv && inst == STOP)) begin ph = 2; drain_left = DRAIN; end
      end
      2: begin drain_left--; if (drain_left == 0) begin ph = 3; m_pulse = 1; end end
      default: if (start) begin ph = 1; model_zero(); end
    endcase
  endtask

  task automatic check_dut(string n, int w, bit sat, logic [1:0] st, logic dn, logic dp,
                           logic [63:0] cyc, logic [63:0] ac, logic [63:0] ht, logic [NUM_CH-1:0] ov);
    logic [63:0] mask = (64'd1 << w) - 64'd1;
    longint mx = (longint'(1) << w) - 1;
    chk({n, ".state"}, 64'(st), 64'(ph));
    chk({n, ".done"}, 64'(dn), 64'(ph == 3));
    chk({n, ".pulse"}, 64'(dp), 64'(m_pulse));
    chk({n, ".cycle"}, cyc, view(m_cyc, w, sat));
    for (int k = 0; k < NUM_CH; k++) begin
      chk($sformatf("%s.acc%0d", n, k), (ac >> (k * w)) & mask, view(m_acc[k], w, sat));
      chk($sformatf("%s.hit%0d", n, k), (ht >> (k * w)) & mask, view(m_hit[k], w, sat));
      chk($sformatf("%s.ovf%0d", n, k), 64'(ov[k]), 64'(m_acc[k] > mx || m_hit[k] > mx));
    end
  endtask

  task automatic check_all();
    check_dut("A", 32, 1, if_a.state_o, if_a.done_o, if_a.done_pulse_o, {32'd0, if_a.cycle_cnt_o},
              if_a.access_cnt_o, if_a.hit_cnt_o, if_a.overflow_o);
    check_dut("B", 8, 1, if_b.state_o, if_b.done_o, if_b.done_pulse_o, {56'd0, if_b.cycle_cnt_o},
              {48'd0, if_b.access_cnt_o}, {48'd0, if_b.hit_cnt_o}, if_b.overflow_o);
    check_dut("C", 8, 0, if_c.state_o, if_c.done_o, if_c.done_pulse_o, {56'd0, if_c.cycle_cnt_o},
              {48'd0, if_c.access_cnt_o}, {48'd0, if_c.hit_cnt_o}, if_c.overflow_o);
  endtask

  // One clock: drive away from the edge, advance the model on the edge, check after it
  task automatic step(bit st, bit sp, bit cl, bit v, logic [31:0] in,
                      logic [NUM_CH-1:0] rq, logic [NUM_CH-1:0] ac, logic [NUM_CH-1:0] l, logic [NUM_CH-1:0] h);
    @(negedge clk);
    start = st; stop = sp; clear = cl; iv = v; inst = in;
    req = rq; acc = ac; lk = l; hit = h;
    @(posedge clk);
    model_edge();
    #1 check_all();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, '0, '0, '0, '0);
  endtask

  initial begin
    model_zero();
    m_pulse = 0;
    #1 check_all();                                   // reset state
    @(negedge clk) rst_n = 1'b1;

    // Basic run: 10 ch0 events, 7 hits, stop by ret, full drain
    step(1, 0, 0, 0, '0, '0, '0, '0, '0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, '0, 2'b01, 2'b01, 2'b01, (i < 7) ? 2'b01 : 2'b00);
    step(0, 0, 0, 1, STOP, '0, '0, '0, '0);
    idle(DRAIN + 2);

    // Qualification gaps, then stop-cycle event counted and DRAIN hits ignored
    step(1, 0, 0, 0, '0, '0, '0, '0, '0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, '0, 2'b11, 2'b11, 2'b00, 2'b11);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, '0, 2'b00, 2'b11, 2'b11, 2'b11);
    step(0, 0, 0, 0, '0, '0, '0, '0, 2'b11);
    step(0, 0, 0, 1, 32'h0000_0013, 2'b10, 2'b10, 2'b10, 2'b00);
    step(0, 0, 0, 1, STOP, 2'b11, 2'b11, 2'b11, 2'b11);
    for (int i = 0; i < DRAIN + 1; i++) step(0, 0, 0, 0, '0, 2'b11, 2'b11, 2'b11, 2'b11);

    // Priority: clear+start in DONE, stop in IDLE, start in RUN, stop+match together
    step(1, 0, 1, 0, '0, '0, '0, '0, '0);
    step(0, 1, 0, 1, STOP, 2'b11, 2'b11, 2'b11, 2'b11);
    step(1, 0, 0, 0, '0, 2'b01, 2'b01, 2'b01, 2'b01);
    step(0, 0, 0, 0, '0, 2'b01, 2'b01, 2'b01, 2'b01);
    step(1, 0, 0, 0, '0, 2'b01, 2'b01, 2'b01, 2'b00);
    step(0, 1, 0, 1, STOP, '0, '0, '0, '0);
    step(1, 0, 0, 0, '0, '0, '0, '0, '0);              // start in DRAIN ignored
    idle(DRAIN + 1);

    // Overflow: 300 qualified events (ch0 hits, ch1 misses)
    step(1, 0, 0, 0, '0, '0, '0, '0, '0);
    for (int i = 0; i < 300; i++) step(0, 0, 0, 0, '0, 2'b11, 2'b11, 2'b11, 2'b01);
    step(0, 1, 0, 0, '0, '0, '0, '0, '0);
    idle(DRAIN + 1);
    step(1, 0, 0, 0, '0, '0, '0, '0, '0);              // re-arm clears sticky overflow

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bit v = 1'($urandom_range(1));
      step($urandom_range(7) == 0, $urandom_range(39) == 0, $urandom_range(199) == 0, v,
           ($urandom_range(24) == 0) ? STOP : $urandom,
           2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
    end

    // Asynchronous reset in the middle of DRAIN
    step(0, 0, 1, 0, '0, '0, '0, '0, '0);
    step(1, 0, 0, 0, '0, '0, '0, '0, '0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, '0, 2'b11, 2'b11, 2'b11, 2'b10);
    step(0, 1, 0, 0, '0, '0, '0, '0, '0);
    idle(2);
    #2 rst_n = 1'b0;
    ph = 0; model_zero(); m_pulse = 0;
    #1 check_all();
    #2 rst_n = 1'b1;
    step(1, 0, 0, 0, '0, '0, '0, '0, '0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, '0, 2'b11, 2'b11, 2'b11, 2'b01);
    step(0, 0, 0, 1, STOP, '0, '0, '0, '0);
    idle(DRAIN + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_perf_monitor.md
Name: cache_perf_monitor

Overview:
Synthesizable, multi-channel cache performance monitor for the riscv_tcm_top SoC. Each channel counts qualified lookup accesses and hits from one cache core (e.g. dcache, icache), using the same qualification the simulation benches apply. Counting starts on command and stops on a configurable instruction-match (default: ret, 32'h0000_8067) or a software stop, followed by a fixed drain period. Counters stay readable after stop, so benches and on-chip debug read one hardware result instead of probing internal nets.

Parameters:
NUM_CH, 2, number of monitored cache channels (1..8)
CNT_W, 32, width of every event and cycle counter (8..64)
STOP_INST, 32'h0000_8067, instruction word that triggers the stop sequence
DRAIN_CYC, 5, cycles spent in DRAIN after a stop (1..255)
SAT_EN, 1, 1 = counters saturate at all-ones; 0 = counters wrap

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_i  in  1  asynchronous, active-low reset
start_i  in  1  one-cycle pulse; arm and clear counters
stop_i  in  1  one-cycle pulse; software stop
clear_i  in  1  one-cycle pulse; abort to IDLE and zero everything
inst_valid_i  in  1  inst_i valid this cycle (fetch accept)
inst_i  in  32  fetched instruction word
ch_req_i  in  NUM_CH  per channel: rd or wr request active
ch_accept_i  in  NUM_CH  per channel: cache accepted request
ch_lookup_i  in  NUM_CH  per channel: cache state is LOOKUP
ch_hit_i  in  NUM_CH  per channel: tag hit in any way
access_cnt_o  out  NUM_CH*CNT_W  qualified accesses; channel k at bits [k*CNT_W +: CNT_W]
hit_cnt_o  out  NUM_CH*CNT_W  qualified hits, same packing
overflow_o  out  NUM_CH  sticky per-channel flag: access or hit counter saturated or wrapped
cycle_cnt_o  out  CNT_W  cycles spent in RUN
state_o  out  2  0 IDLE, 1 RUN, 2 DRAIN, 3 DONE
done_o  out  1  level; high in DONE
done_pulse_o  out  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset (rst_i low, asynchronous): state IDLE. All counters, overflow_o, done_o, done_pulse_o and the drain counter are 0.
- Qualified event on channel k: ch_req_i[k] & ch_accept_i[k] & ch_lookup_i[k]. It increments access k. If ch_hit_i[k] is also high, it increments hit k.
- A hit is never counted without its access. hit_cnt never exceeds access_cnt while SAT_EN=1.
- Counting occurs only in RUN. Counters update on the clock edge after the event, so outputs have 1 cycle of latency.
- cycle_cnt increments every RUN cycle, including the stop cycle.
- State transitions:
  - IDLE: start_i -> RUN; all counters and overflow_o are zeroed on the same edge.
  - RUN: (inst_valid_i & inst_i==STOP_INST) or stop_i -> DRAIN, with the drain counter loaded to DRAIN_CYC-1. Events present in the stop-detection cycle are counted.
  - DRAIN: counters are frozen. The drain counter decrements each cycle. At 0 -> DONE, done_pulse_o=1 for one cycle, done_o=1.
  - DONE: values held. start_i -> RUN with counters zeroed (re-arm).
- start_i is ignored in RUN and DRAIN.
- clear_i in any state -> IDLE with everything zeroed. clear_i has priority over start_i and stop_i in the same cycle.
- If stop_i and an instruction match occur together, there is a single stop.
- inst_i is ignored when inst_valid_i is low, and outside RUN.
- Saturation, SAT_EN=1: a counter at all-ones holds its value and sets overflow_o[k]. cycle_cnt also saturates.
- Wrap, SAT_EN=0: a counter rolls over to 0 and sets overflow_o[k].
- overflow_o[k] is sticky until start_i or clear_i.
- Reset mid-RUN or mid-DRAIN returns the block to IDLE immediately, asynchronously.

Test Plan:
- Reset then start_i. On ch0, 10 cycles with req/accept/lookup high, hit high on 7 of them; ch1 idle. Then inst 0x00008067 valid -> access_cnt ch0=10, hit_cnt ch0=7, ch1 counts 0, state DRAIN for 5 cycles, done_pulse_o once, done_o=1.
- Qualification: on ch0, accept high with lookup low for 3 cycles, and req low with accept+lookup high for 2 cycles -> counts remain 0. hit_i high with no qualified event -> hit_cnt 0.
- Stop-cycle boundary: qualified hit on the same cycle as the stop instruction -> that event is counted. A hit during DRAIN is not counted. cycle_cnt equals the number of RUN cycles exactly.
- CNT_W=8, SAT_EN=1, 300 qualified hits -> access=hit=255, overflow_o[0]=1. With SAT_EN=0 -> access=hit=44, overflow_o[0]=1.
- Priority: clear_i and start_i pulsed together in DONE -> state IDLE, all zero. stop_i in IDLE -> no effect. start_i during RUN -> counts not cleared.
- Drive rst_i low in the middle of DRAIN (asynchronously, between edges) -> state_o=0 and counters=0 before the next edge. After release, start_i -> normal operation.
